flit_demux: RTL and testbench

FLIT_DEMUX -- requirements
Module: flit_demux

---
 rtl/flit_demux.sv | 133 +++++++++++++
 tb/tb_flit_demux.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/flit_demux.sv
// Packet-aware 1:2 flit demultiplexer with a single output register; the HEAD flit picks the route for its packet.
// Optional protocol-error flag is built only when DEMUX_ERRCHK_EN is defined.
module flit_demux #(
  parameter int DATAW = 66,
  parameter int VCHW  = 2
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [DATAW-1:0] idata,
  input  logic             ivalid,
  input  logic [VCHW-1:0]  ivch,
  output logic             iready,
  output logic [DATAW-1:0] odata_0,
  output logic [DATAW-1:0] odata_1,
  output logic             ovalid_0,
  output logic             ovalid_1,
  output logic [VCHW-1:0]  ovch_0,
  output logic [VCHW-1:0]  ovch_1,
  input  logic             oready_0,
  input  logic             oready_1,
  output logic             err
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [1:0] T_NONE = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_DATA = 2'b11;

  state_t             state_q, state_d;
  logic               route_q, route_d;
  logic               full_q, port_q;
  logic [DATAW-1:0]   data_q;
  logic [VCHW-1:0]    vch_q;
  logic [1:0]         ftype;
  logic               consumed, accept, load, load_port;

  assign ftype    = idata[DATAW-1 -: 2];
  assign consumed = full_q && (port_q ? oready_1 : oready_0);
  assign iready   = !full_q || consumed;
  assign accept   = ivalid && iready;

  always_ff @(posedge clk) begin
    if (!rst_) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      case (state_q)
        IDLE: if (ftype == T_HEAD) state_d = BUSY;
        BUSY: if (ftype == T_TAIL) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef DEMUX_ERRCHK_EN
  logic proto_err;
`endif

  // Stray HEAD in BUSY is forwarded as a body flit; the route stays put.
  always_comb begin
    load      = 1'b0;
    load_port = route_q;
    route_d   = route_q;
`ifdef DEMUX_ERRCHK_EN
    proto_err = 1'b0;
`endif
    if (accept) begin
      case (state_q)
        IDLE: begin
          if (ftype == T_HEAD) begin
            load      = 1'b1;
            load_port = idata[0];
            route_d   = idata[0];
          end
`ifdef DEMUX_ERRCHK_EN
          if (ftype == T_DATA || ftype == T_TAIL) proto_err = 1'b1;
`endif
        end
        BUSY: begin
          if (ftype != T_NONE) load = 1'b1;
`ifdef DEMUX_ERRCHK_EN
          if (ftype == T_HEAD) proto_err = 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      full_q  <= 1'b0;
      route_q <= 1'b0;
      port_q  <= 1'b0;
      data_q  <= '0;
      vch_q   <= '0;
    end else begin
      route_q <= route_d;
      if (load) begin
        full_q <= 1'b1;
        port_q <= load_port;
        data_q <= idata;
        vch_q  <= ivch;
      end else if (consumed) begin
        full_q <= 1'b0;
      end
    end
  end

`ifdef DEMUX_ERRCHK_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (!rst_)          err_q <= 1'b0;
    else if (proto_err) err_q <= 1'b1;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign ovalid_0 = full_q && !port_q;
  assign ovalid_1 = full_q &&  port_q;
  assign odata_0  = ovalid_0 ? data_q : '0;
  assign odata_1  = ovalid_1 ? data_q : '0;
  assign ovch_0   = ovalid_0 ? vch_q  : '0;
  assign ovch_1   = ovalid_1 ? vch_q  : '0;

endmodule

// File: tb/tb_flit_demux.sv
// Scoreboard bench for flit_demux: the driver pushes expected flits per port, a negedge monitor pops and compares.
module tb_flit_demux;
  localparam int DATAW = 66;
  localparam int VCHW  = 2;
  localparam logic [1:0] NONE = 2'b00, HEAD = 2'b01, TAIL = 2'b10, DATA = 2'b11;
`ifdef DEMUX_ERRCHK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_;
  logic [DATAW-1:0] idata;
  logic             ivalid;
  logic [VCHW-1:0]  ivch;
  logic             iready;
  logic [DATAW-1:0] odata_0, odata_1;
  logic             ovalid_0, ovalid_1;
  logic [VCHW-1:0]  ovch_0, ovch_1;
  logic             oready_0, oready_1;
  logic             err;

  flit_demux #(.DATAW(DATAW), .VCHW(VCHW)) dut (
    .clk(clk), .rst_(rst_), .idata(idata), .ivalid(ivalid), .ivch(ivch), .iready(iready),
    .odata_0(odata_0), .odata_1(odata_1), .ovalid_0(ovalid_0), .ovalid_1(ovalid_1),
    .ovch_0(ovch_0), .ovch_1(ovch_1), .oready_0(oready_0), .oready_1(oready_1), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DATAW-1:0] d;
    logic [VCHW-1:0]  v;
    int               acc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  bit   seen[2];
  int   checks = 0, errors = 0, waits = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon_port(input int p);
    logic ov, ordy;
    logic [DATAW-1:0] od;
    logic [VCHW-1:0] ovc;
    exp_t e;
    int sz;
    ov   = p[0] ? ovalid_1 : ovalid_0;
    ordy = p[0] ? oready_1 : oready_0;
    od   = p[0] ? odata_1  : odata_0;
    ovc  = p[0] ? ovch_1   : ovch_0;
    sz   = p[0] ? q1.size() : q0.size();
    if (!ov) begin
      chk($sformatf("idle_zero_p%0d", p), {od, ovc}, '0);
    end else if (sz == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_p%0d: got flit %0h expected none (cycle %0d)", p, od, cyc);
    end else begin
      e = p[0] ? q1[0] : q0[0];
      if (!seen[p]) begin
        chk($sformatf("latency_p%0d", p), cyc, e.acc + 1);
        seen[p] = 1'b1;
      end
      chk($sformatf("data_p%0d", p), od, e.d);
      chk($sformatf("vch_p%0d", p), ovc, e.v);
      if (ordy) begin
        if (p[0]) void'(q1.pop_front());
        else      void'(q0.pop_front());
        seen[p] = 1'b0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_) begin
      mon_port(0);
      mon_port(1);
    end
  end

  // Drive one flit, wait (bounded) for acceptance, then record where it must appear.
  task automatic send(input logic [1:0] t, input logic [63:0] pl, input logic [VCHW-1:0] v, input int exp_port);
    int n;
    exp_t e;
    idata  = {t, pl};
    ivch   = v;
    ivalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!iready && n < 50) begin
      @(negedge clk);
      n++;
    end
    waits += n;
    if (!iready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got iready=0 expected 1 within 50 cycles (flit %0h)", idata);
    end else if (exp_port >= 0) begin
      e.d = idata; e.v = v; e.acc = cyc;
      if (exp_port == 1) q1.push_back(e);
      else               q0.push_back(e);
    end
    @(posedge clk);
    #1;
    ivalid = 1'b0;
    idata  = '0;
    ivch   = '0;
  endtask

  initial begin
    rst_ = 1'b0; ivalid = 1'b0; idata = '0; ivch = '0;
    oready_0 = 1'b1; oready_1 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_ = 1'b1;
    @(negedge clk);
    chk("rst_ovalid", {ovalid_0, ovalid_1}, 2'b00);
    chk("rst_odata", {odata_0, odata_1}, '0);
    chk("rst_ovch", {ovch_0, ovch_1}, '0);
    chk("rst_iready", iready, 1'b1);
    chk("rst_err", err, 1'b0);
    @(posedge clk); #1;

    // Long packet to port 1, vch per flit, full throughput.
    waits = 0;
    send(HEAD, 64'h09, 2'b10, 1);
    for (int i = 0; i < 20; i++) send(DATA, 64'h100 + 64'(i), 2'b01, 1);
    send(TAIL, 64'h1FF, 2'b11, 1);
    chk("port1_no_stall", waits, 0);
    chk("port1_err", err, 1'b0);

    // Port 0 with a 5-cycle downstream stall.
    send(HEAD, 64'h04, 2'b00, 0);
    send(DATA, 64'h200, 2'b01, 0);
    oready_0 = 1'b0;
    fork
      begin
        repeat (5) @(posedge clk);
        #1 oready_0 = 1'b1;
      end
    join_none
    @(negedge clk);
    chk("stall_iready", iready, 1'b0);
    @(posedge clk); #1;
    send(DATA, 64'h201, 2'b10, 0);
    send(DATA, 64'h202, 2'b11, 0);
    send(TAIL, 64'h203, 2'b00, 0);

    // Back-to-back packets: port 1 then port 0, no bubble.
    waits = 0;
    send(HEAD, 64'h0B, 2'b01, 1);
    send(DATA, 64'h300, 2'b01, 1);
    send(TAIL, 64'h301, 2'b01, 1);
    send(HEAD, 64'h10, 2'b10, 0);
    send(DATA, 64'h302, 2'b10, 0);
    send(TAIL, 64'h303, 2'b10, 0);
    chk("b2b_no_stall", waits, 0);

    // Protocol errors: DATA in IDLE, stray HEAD in BUSY, NONE flits.
    send(NONE, 64'h5, 2'b00, -1);
    send(DATA, 64'hBAD, 2'b00, -1);
    send(HEAD, 64'h02, 2'b01, 0);
    send(HEAD, 64'h03, 2'b10, 0);
    send(NONE, 64'h6, 2'b00, -1);
    send(DATA, 64'h400, 2'b11, 0);
    send(TAIL, 64'h401, 2'b00, 0);
    repeat (2) @(posedge clk); #1;
    chk("err_flag", err, ERR_EXP);

    // Reset mid-packet while the 3rd DATA is still held.
    send(HEAD, 64'h06, 2'b00, 0);
    send(DATA, 64'h500, 2'b00, 0);
    send(DATA, 64'h501, 2'b00, 0);
    send(DATA, 64'h502, 2'b00, 0);
    oready_0 = 1'b0;
    rst_ = 1'b0;
    @(posedge clk); #1;
    rst_ = 1'b1;
    q0.delete(); q1.delete();
    seen[0] = 1'b0; seen[1] = 1'b0;
    oready_0 = 1'b1;
    @(negedge clk);
    chk("mrst_ovalid", {ovalid_0, ovalid_1}, 2'b00);
    chk("mrst_odata", {odata_0, odata_1}, '0);
    chk("mrst_iready", iready, 1'b1);
    chk("mrst_err", err, 1'b0);
    @(posedge clk); #1;
    send(DATA, 64'h503, 2'b00, -1);
    send(HEAD, 64'h07, 2'b10, 1);
    send(DATA, 64'h600, 2'b01, 1);
    send(TAIL, 64'h601, 2'b11, 1);

    for (int i = 0; i < 50 && (q0.size() != 0 || q1.size() != 0); i++) @(posedge clk);
    repeat (2) @(posedge clk);
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
